// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector: run-time pattern, length and overlap
// mode, valid-qualified sampling, registered match pulse and saturating match counter.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0011_0011,
  parameter int                 RST_LEN     = 6,
  parameter bit                 RST_OVERLAP = 1'b1,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a,
  input  logic               a_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   cur_len
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'((RST_LEN > MAX_LEN) ? MAX_LEN : RST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [MAX_LEN-1:0] pat, hist, hist_nxt, mask;
  logic [LEN_W-1:0]   len, fill, fill_inc, cfg_len_c;
  logic               ovl, sample, match;

  // NOTE: every always_comb output gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    hist_nxt  = {hist[MAX_LEN-2:0], a};
    fill_inc  = (fill == MAX_LEN_L) ? fill : fill + LEN_W'(1);
    cfg_len_c = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    sample = a_valid & ~cfg_we;
    // Match is judged on the post-shift history and post-increment fill.
    match  = sample && (len != '0) && (fill_inc >= len) &&
             (((hist_nxt ^ pat) & mask) == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat      <= RST_PATTERN;
      len      <= RST_LEN_C;
      ovl      <= RST_OVERLAP;
      hist     <= '0;
      fill     <= '0;
      detected <= 1'b0;
    end else if (cfg_we) begin
      pat      <= cfg_pattern;
      len      <= cfg_len_c;
      ovl      <= cfg_overlap;
      fill     <= '0;
      detected <= 1'b0;
    end else if (a_valid) begin
      hist     <= hist_nxt;
      fill     <= (match && !ovl) ? '0 : fill_inc;
      detected <= match;
    end else begin
      detected <= 1'b0;
    end
  end

  // Clear wins over a coincident match; the detected pulse is unaffected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= '0;
    end else if (match && (match_count != CNT_MAX)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

  assign cur_len = len;

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-sequence detector. It replaces the fixed-pattern detectors with one block whose pattern, pattern length and overlap mode are loaded at run time. It also qualifies input bits with a valid strobe and keeps a saturating match counter. It sits on a serial input bit stream and feeds a one-cycle `detected` pulse plus `match_count` to the control/status logic.

## Interface

- MAX_LEN, 8: maximum pattern length in bits; must be ≥ 2.
- CNT_W, 8: width of `match_count`.
- RST_PATTERN, 8'b0011_0011: pattern loaded at reset.
  - Right-aligned: bit 0 is the last bit received.
- RST_LEN, 6: pattern length loaded at reset (reset config detects "110011").
- RST_OVERLAP, 1: overlap mode loaded at reset.
- LEN_W, $clog2(MAX_LEN+1): derived width of the length fields.

Ports:

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- a  in  1  serial input bit.
- a_valid  in  1  `a` is sampled only when high.
- cfg_we  in  1  load the `cfg_*` fields this cycle.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned.
  - `cfg_pattern[cfg_len-1]` is the first bit expected; `cfg_pattern[0]` is the last.
- cfg_len  in  LEN_W  new pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of `match_count`.
- detected  out  1  registered match pulse.
- match_count  out  CNT_W  saturating count of matches.
- cur_len  out  LEN_W  active (clamped) pattern length.

## Operation

**Registers**
- Active config: `pat`, `len`, `ovl`.
- History shift register `hist[MAX_LEN-1:0]`; the newest bit is `hist[0]`.
- Fill counter `fill`, 0..MAX_LEN, saturating.
- `detected`, `match_count`.

**Length clamping.** `len` is the clamped `cfg_len`: values above MAX_LEN are stored as MAX_LEN. `len` = 0 disables detection; `detected` stays 0.

**Sample.** On a cycle with `a_valid`=1 and `cfg_we`=0:
- `hist` ← {`hist[MAX_LEN-2:0]`, `a`}.
- `fill` ← min(`fill`+1, MAX_LEN).

**Match.** Evaluated combinationally on the post-shift values. A match requires all of:
- `len` ≠ 0;
- new `fill` ≥ `len`;
- new `hist[len-1:0]` == `pat[len-1:0]`.
- Bits at and above `len` are masked in both operands.

**On a match**
- `detected` ← 1.
- `match_count` increments, saturating at 2^CNT_W−1.
- If `ovl`=0, `fill` ← 0. History bits are kept, but the next match needs `len` fresh bits.
- If `ovl`=1, `fill` is unchanged.

**Idle cycles.** Any cycle without a sample sets `detected` ← 0. `hist` and `fill` hold.

**Config load (`cfg_we`=1)**
- `pat`, `len`, `ovl` ← `cfg_*` fields.
- `fill` ← 0 and `detected` ← 0.
- `a` is not sampled that cycle, even if `a_valid`=1.
- `match_count` is untouched.

**Counter clear.** `cnt_clr`=1 sets `match_count` ← 0. It wins over a simultaneous match: the count is 0, but `detected` still pulses.

**Reset** (`rst_n`=0, asynchronous assert):
- `pat`/`len`/`ovl` ← RST_PATTERN / clamped RST_LEN / RST_OVERLAP.
- `hist` ← 0, `fill` ← 0.
- `detected` ← 0, `match_count` ← 0.
- `cur_len` ← clamped RST_LEN.
- Reset asserted mid-stream discards all partial progress.

## Timing

- `detected` is registered. It is high for exactly the one cycle after the rising edge that sampled the last bit of a match. The one-edge latency matches the existing FSM detectors.
- Back-to-back matches (overlap mode, period `len`, or a pattern with a self-overlapping suffix) give consecutive or periodic pulses. `detected` can stay high over multiple cycles only when each of those edges completes a match.
- New config takes effect on the edge where `cfg_we` is sampled. `cur_len` updates on that same edge.
- `match_count` updates on the same edge as `detected`.
- Deassertion of `rst_n` is assumed synchronised externally. The first sample is allowed on the first edge after release.

## Test plan

1. **Reset config, overlap.** Stream 1,1,0,0,1,1,0,0,1,1 with `a_valid`=1.
   - `detected` is high after bits 6 and 10 only; `match_count`=2.
2. **Non-overlap.** Load `cfg_pattern`=8'b0000_1010, `cfg_len`=4, `cfg_overlap`=0, then stream 1,0,1,0,1,0,1,0.
   - Pulses after bits 4 and 8; `match_count` +2.
   - Repeat with `cfg_overlap`=1: pulses after bits 4, 6, 8.
3. **Gaps in `a_valid`.** Stream the 4-bit pattern 1010 with `a_valid`=0 idle cycles inserted between bits.
   - Match is still detected after the 4th valid bit.
   - `detected` is 0 on every idle cycle.
4. **Reconfig mid-pattern.** Feed 1,1,0,0 of "110011", pulse `cfg_we` with the same config, then feed 1,1.
   - No detection, because `fill` was cleared.
   - Feeding the full 6 bits afterwards detects.
5. **Boundaries.** `cfg_len`=0: no detection on any stream. `cfg_len`=15 with MAX_LEN=8: `cur_len`=8 and an 8-bit match works. With CNT_W=2, drive 5 matches: count stops at 3. `cnt_clr` on a match edge: count 0, `detected` 1.
6. **Async reset mid-stream.** Assert `rst_n`=0 between clock edges after 5 bits of "110011".
   - Outputs go to 0 immediately.
   - After release, the 6th bit alone gives no match; `cur_len`=6.
